// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples scsn/sclk/mosi on clk, pushes received bytes to an
// RX FIFO, shifts TX FIFO words out on miso MSB first, and reports per-frame status.
module spi_target #(
   parameter int              DATA = 8,
   parameter logic [DATA-1:0] FILL = {DATA{1'b1}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            scsn,
   input  logic            sclk,
   input  logic            mosi,
   output logic            miso,
   output logic [DATA-1:0] wdata,
   output logic            wr,
   input  logic            full,
   input  logic [DATA-1:0] rdata,
   output logic            rd,
   input  logic            empty,
   output logic            busy,
   output logic            done,
   output logic [15:0]     frame_bytes,
   output logic            overrun,
   output logic            underrun
);

   localparam int BW = $clog2(DATA);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic            scsn_p0, scsn_p1, scsn_p2;
   logic            sclk_p0, sclk_p1, sclk_p2;
   logic            mosi_p0, mosi_p1;
   logic            cs_fall, cs_rise, sck_rise, sck_fall;
   logic [1:0]      state;
   logic [BW-1:0]   bitcnt;
   logic [DATA-1:0] rx_sh, tx_sh;
   logic [15:0]     byte_cnt;
   logic            fresh_p0, fresh_p1, armed;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Synchroniser stage: p0/p1 resolve metastability, p2 holds the previous sample
   always_ff @(posedge clk) begin
      if (!rst) begin
         scsn_p0 <= 1'b1; scsn_p1 <= 1'b1; scsn_p2 <= 1'b1;
         sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
         mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
      end else begin
         scsn_p0 <= scsn; scsn_p1 <= scsn_p0; scsn_p2 <= scsn_p1;
         sclk_p0 <= sclk; sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
         mosi_p0 <= mosi; mosi_p1 <= mosi_p0;
      end
   end

   assign cs_fall  =  scsn_p2 & ~scsn_p1;
   assign cs_rise  = ~scsn_p2 &  scsn_p1;
   assign sck_rise = ~sclk_p2 &  sclk_p1;
   assign sck_fall =  sclk_p2 & ~sclk_p1;

   assign miso = (state == ST_ACTIVE) && tx_sh[DATA-1];

   // Frame control stage; armed blocks a frame until scsn is genuinely seen high after reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         wr          <= 1'b0;
         rd          <= 1'b0;
         wdata       <= '0;
         frame_bytes <= '0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
         fresh_p0    <= 1'b0;
         fresh_p1    <= 1'b0;
         armed       <= 1'b0;
      end else begin
         wr       <= 1'b0;
         rd       <= 1'b0;
         done     <= 1'b0;
         fresh_p0 <= 1'b1;
         fresh_p1 <= fresh_p0;
         if (fresh_p1 && scsn_p1) armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cs_fall && armed) begin
                  state    <= ST_ACTIVE;
                  busy     <= 1'b1;
                  bitcnt   <= '0;
                  rx_sh    <= '0;
                  byte_cnt <= '0;
                  overrun  <= 1'b0;
                  underrun <= 1'b0;
                  if (!empty) begin
                     tx_sh <= rdata;
                     rd    <= 1'b1;
                  end else begin
                     tx_sh    <= FILL;
                     underrun <= 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state <= ST_DONE;
               end else if (sck_rise) begin
                  rx_sh <= {rx_sh[DATA-2:0], mosi_p1};
                  if (bitcnt == BW'(DATA-1)) begin
                     wdata    <= {rx_sh[DATA-2:0], mosi_p1};
                     bitcnt   <= '0;
                     byte_cnt <= sat_inc(byte_cnt);
                     if (!full) wr      <= 1'b1;
                     else       overrun <= 1'b1;
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end else if (sck_fall) begin
                  // bitcnt==0 here means a byte boundary was just crossed: fetch the next word
                  if (bitcnt == '0) begin
                     if (!empty) begin
                        tx_sh <= rdata;
                        rd    <= 1'b1;
                     end else begin
                        tx_sh    <= FILL;
                        underrun <= 1'b1;
                     end
                  end else begin
                     tx_sh <= {tx_sh[DATA-2:0], 1'b0};
                  end
               end
            end
            ST_DONE: begin
               frame_bytes <= byte_cnt;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Randomised bench for spi_target: an SPI master drives frames, a scoreboard holds the
// expected RX bytes, miso bits and per-frame status derived from the frame-level rules.
module tb_spi_target;

   localparam int         DATA = 8;
   localparam logic [7:0] FILL = 8'hFF;

   logic        clk = 1'b0, rst = 1'b0;
   logic        scsn = 1'b1, sclk = 1'b0, mosi = 1'b0, full = 1'b0, empty = 1'b1;
   logic [7:0]  rdata = 8'h00;
   logic        miso, wr, rd, busy, done, overrun, underrun;
   logic [7:0]  wdata;
   logic [15:0] frame_bytes;

   always #5 clk = ~clk;

   spi_target #(.DATA(DATA), .FILL(FILL)) dut (
      .clk(clk), .rst(rst), .scsn(scsn), .sclk(sclk), .mosi(mosi), .miso(miso),
      .wdata(wdata), .wr(wr), .full(full), .rdata(rdata), .rd(rd), .empty(empty),
      .busy(busy), .done(done), .frame_bytes(frame_bytes), .overrun(overrun),
      .underrun(underrun)
   );

   typedef struct {
      int   fb;
      logic ov;
      logic un;
      int   rdn;
      int   wrn;
   } frame_t;

   int         n_tests = 0, n_fail = 0;
   logic [7:0] txq[$];
   logic [7:0] exp_rx[$];
   logic       exp_miso[$];
   frame_t     exp_fr[$];
   int         rd_cnt = 0, wr_cnt = 0, done_cnt = 0, frames_issued = 0;

   // Frame description filled in by the stimulus before each run_frame call
   logic [7:0] mosi_b[8];
   logic [7:0] tx_b[8];
   int         tx_n;
   logic [7:0] full_m;
   int         nbits;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic fifo_pins();
      empty = (txq.size() == 0);
      rdata = empty ? 8'h00 : txq[0];
   endtask

   // TX FIFO emulation plus RX / status scoreboard
   always @(negedge clk) begin
      frame_t f;
      if (rd) begin
         if (txq.size() > 0) void'(txq.pop_front());
         rd_cnt++;
         fifo_pins();
      end
      if (wr) begin
         wr_cnt++;
         if (exp_rx.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wr_unexpected: got wdata %0h, expected no write", wdata);
         end else check("wdata", wdata, exp_rx.pop_front());
      end
      if (done) begin
         done_cnt++;
         if (exp_fr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_unexpected: got done=1, expected no frame end");
         end else begin
            f = exp_fr.pop_front();
            check("frame_bytes", frame_bytes, f.fb);
            check("overrun", overrun, f.ov);
            check("underrun", underrun, f.un);
            check("rd_count", rd_cnt, f.rdn);
            check("wr_count", wr_cnt, f.wrn);
            check("busy_at_done", busy, 0);
         end
         rd_cnt = 0;
         wr_cnt = 0;
      end
   end

   always @(posedge sclk) begin
      if (exp_miso.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL miso_unexpected: got sclk edge with miso=%0b, expected none", miso);
      end else check("miso", miso, exp_miso.pop_front());
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, miso, 0);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_wr"}, wr, 0);
      check({tag, "_rd"}, rd, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_frame_bytes"}, frame_bytes, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_underrun"}, underrun, 0);
   endtask

   // Drives one frame; with abort set, rst is pulled mid-frame while scsn stays low
   task automatic run_frame(input int hi, input int lo, input int gap, input bit abort);
      int         complete, loads, nfull, b;
      logic       ov;
      logic [7:0] lb;
      frame_t     f;
      complete = nbits / 8;
      loads    = complete + 1;
      nfull    = 0;
      ov       = 1'b0;
      txq.delete();
      for (int i = 0; i < tx_n; i++) txq.push_back(tx_b[i]);
      fifo_pins();
      for (int k = 0; k < complete; k++) begin
         if (full_m[k]) begin
            ov = 1'b1;
            nfull++;
         end else exp_rx.push_back(mosi_b[k]);
      end
      if (!abort) begin
         f.fb  = complete;
         f.ov  = ov;
         f.un  = (loads > tx_n);
         f.rdn = (loads < tx_n) ? loads : tx_n;
         f.wrn = complete - nfull;
         exp_fr.push_back(f);
         frames_issued++;
      end
      scsn = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         b    = i / 8;
         full = full_m[b];
         mosi = mosi_b[b][7 - (i % 8)];
         repeat ((i == 0) ? ((lo > 5) ? lo : 5) : lo) @(negedge clk);
         lb = (b < tx_n) ? tx_b[b] : FILL;
         exp_miso.push_back(lb[7 - (i % 8)]);
         sclk = 1'b1;
         repeat (hi) @(negedge clk);
         if (i == 0) check("busy_in_frame", busy, 1);
         sclk = 1'b0;
      end
      repeat (lo) @(negedge clk);
      if (abort) begin
         rst = 1'b0;
         repeat (2) @(negedge clk);
         check_reset_outputs("rst_mid");
         exp_miso.delete();
         exp_rx.delete();
         rd_cnt = 0;
         wr_cnt = 0;
         rst    = 1'b1;
         repeat (20) @(negedge clk);
         check("rst_release_rd", rd_cnt, 0);
         check("rst_release_wr", wr_cnt, 0);
         check("rst_release_busy", busy, 0);
      end
      scsn = 1'b1;
      full = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30 && done_cnt < frames_issued; i++) @(negedge clk);
      if (done_cnt < frames_issued) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: got %0d frame ends, expected %0d", done_cnt, frames_issued);
         done_cnt = frames_issued;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (6) @(negedge clk);

      // Two bytes out and in, FIFO holding A5,3C
      mosi_b[0] = 8'h5A; mosi_b[1] = 8'hC3;
      tx_b[0] = 8'hA5; tx_b[1] = 8'h3C; tx_n = 2;
      full_m = 8'h00; nbits = 16;
      run_frame(4, 4, 6, 0); wait_done();

      // Empty TX FIFO: FILL bytes only
      mosi_b[0] = 8'h12; mosi_b[1] = 8'h34; mosi_b[2] = 8'h56;
      tx_n = 0; full_m = 8'h00; nbits = 24;
      run_frame(4, 4, 6, 0); wait_done();

      // RX FIFO full during the second of three bytes
      mosi_b[0] = 8'h81; mosi_b[1] = 8'h7E; mosi_b[2] = 8'h0F;
      tx_b[0] = 8'h11; tx_b[1] = 8'h22; tx_b[2] = 8'h33; tx_b[3] = 8'h44; tx_n = 4;
      full_m = 8'h02; nbits = 24;
      run_frame(5, 4, 6, 0); wait_done();

      // Frame cut after 13 sclk cycles
      mosi_b[0] = 8'hE7; mosi_b[1] = 8'h99;
      tx_b[0] = 8'h5C; tx_b[1] = 8'hC5; tx_n = 2;
      full_m = 8'h00; nbits = 13;
      run_frame(4, 4, 6, 0); wait_done();

      // Reset mid-byte with scsn held low, then a normal frame
      mosi_b[0] = 8'hB4; mosi_b[1] = 8'h2D;
      tx_n = 0; full_m = 8'h00; nbits = 11;
      run_frame(4, 4, 4, 1);
      mosi_b[0] = 8'h3A;
      tx_b[0] = 8'h6B; tx_b[1] = 8'h90; tx_n = 2;
      full_m = 8'h00; nbits = 8;
      run_frame(4, 4, 6, 0); wait_done();

      // Back-to-back frames with a 4-clk scsn high gap
      mosi_b[0] = 8'hAA; mosi_b[1] = 8'h55;
      tx_n = 0; full_m = 8'h01; nbits = 16;
      run_frame(4, 4, 4, 0);
      mosi_b[0] = 8'hC9;
      tx_b[0] = 8'h1E; tx_b[1] = 8'h2F; tx_b[2] = 8'h3D; tx_n = 3;
      full_m = 8'h00; nbits = 8;
      run_frame(4, 4, 6, 0); wait_done();

      // Randomised frames
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 8; i++) begin
            mosi_b[i] = 8'($urandom);
            tx_b[i]   = 8'($urandom);
         end
         tx_n   = $urandom_range(0, 5);
         full_m = 8'($urandom) & 8'($urandom) & 8'($urandom);
         nbits  = $urandom_range(1, 4) * 8;
         if ($urandom_range(0, 3) == 0) nbits += $urandom_range(1, 7);
         run_frame($urandom_range(4, 6), $urandom_range(4, 6), $urandom_range(4, 8), 0);
         wait_done();
      end

      repeat (10) @(negedge clk);
      check("leftover_rx", exp_rx.size(), 0);
      check("leftover_miso", exp_miso.size(), 0);
      check("leftover_frames", exp_fr.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion, expected bench end");
      $fatal(1, "timeout");
   end

endmodule
